// File: rtl/conv_ctrl_pkg.sv
// Shared types and constants for the convolution sequencing controller.
package conv_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        LD_FILT,
        LD_INPUT,
        LD_TABLE,
        WRITE,
        DONE
    } state_e;

    localparam logic [1:0] MSEL_X = 2'b00;
    localparam logic [1:0] MSEL_Y = 2'b01;
    localparam logic [1:0] MSEL_Z = 2'b10;

    localparam logic PC_SEL_BASE = 1'b0;
    localparam logic PC_SEL_INC  = 1'b1;

    localparam int unsigned FILT_BEATS_DEF = 4;
    localparam int unsigned IN_BEATS_DEF   = 16;
    localparam int unsigned WINDOWS_DEF    = 13;

    localparam int unsigned BEAT_W = 5;
    localparam int unsigned WIN_W  = 4;

    // Every datapath strobe driven by the controller (err is kept separately).
    typedef struct packed {
        logic       x_sel;
        logic       y_sel;
        logic       z_sel;
        logic       x_en;
        logic       y_en;
        logic       z_en;
        logic [1:0] mem_in_sel;
        logic       mem_rd;
        logic       mem_wr;
        logic       filt_ld;
        logic       filt_count_en;
        logic       input_en;
        logic       input_count_en;
        logic       tab_count_ld;
        logic       table_count_en;
        logic       table_ld;
        logic       busy;
        logic       done;
    } ctrl_t;

    // Moore decode of a state; win_last suppresses the table advance on the final write.
    function automatic ctrl_t decode(state_e st, logic win_last);
        ctrl_t c;
        c = '0;
        unique case (st)
            IDLE: ;
            INIT: begin
                c.x_sel        = PC_SEL_BASE;
                c.y_sel        = PC_SEL_BASE;
                c.z_sel        = PC_SEL_BASE;
                c.x_en         = 1'b1;
                c.y_en         = 1'b1;
                c.z_en         = 1'b1;
                c.tab_count_ld = 1'b1;
                c.busy         = 1'b1;
            end
            LD_FILT: begin
                c.mem_in_sel    = MSEL_X;
                c.mem_rd        = 1'b1;
                c.filt_ld       = 1'b1;
                c.filt_count_en = 1'b1;
                c.x_en          = 1'b1;
                c.x_sel         = PC_SEL_INC;
                c.busy          = 1'b1;
            end
            LD_INPUT: begin
                c.mem_in_sel     = MSEL_Y;
                c.mem_rd         = 1'b1;
                c.input_en       = 1'b1;
                c.input_count_en = 1'b1;
                c.y_en           = 1'b1;
                c.y_sel          = PC_SEL_INC;
                c.busy           = 1'b1;
            end
            LD_TABLE: begin
                c.table_ld = 1'b1;
                c.busy     = 1'b1;
            end
            WRITE: begin
                c.mem_in_sel     = MSEL_Z;
                c.mem_wr         = 1'b1;
                c.z_en           = 1'b1;
                c.z_sel          = PC_SEL_INC;
                c.table_count_en = ~win_last;
                c.busy           = 1'b1;
            end
            DONE: begin
                c.done = 1'b1;
                c.busy = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/conv_shadow_counter.sv
// Shadow beat/window counter: synchronous clear, increment, and last-value compare.
module conv_shadow_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic [W-1:0] last_i,
    output logic         last_c_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Clear has priority over increment.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_c_o = (count_q == last_i);

endmodule

// File: rtl/conv_controller.sv
// Sequencing FSM for the convolution datapath with carry-out cross-checking.
module conv_controller
    import conv_ctrl_pkg::*;
#(
    parameter int unsigned FILT_BEATS = FILT_BEATS_DEF,
    parameter int unsigned IN_BEATS   = IN_BEATS_DEF,
    parameter int unsigned WINDOWS    = WINDOWS_DEF
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       filt_cout_i,
    input  logic       input_i_cout_i,
    input  logic       table_cout_i,
    output logic       x_sel_o,
    output logic       y_sel_o,
    output logic       z_sel_o,
    output logic       x_en_o,
    output logic       y_en_o,
    output logic       z_en_o,
    output logic [1:0] mem_in_sel_o,
    output logic       mem_rd_o,
    output logic       mem_wr_o,
    output logic       filt_ld_o,
    output logic       filt_count_en_o,
    output logic       input_en_o,
    output logic       input_count_en_o,
    output logic       tab_count_ld_o,
    output logic       table_count_en_o,
    output logic       table_ld_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    localparam logic [BEAT_W-1:0] FILT_LAST = BEAT_W'(FILT_BEATS - 1);
    localparam logic [BEAT_W-1:0] IN_LAST   = BEAT_W'(IN_BEATS - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOWS - 1);

    state_e            state_q, state_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic              err_q, err_d;
    logic              mismatch;
    logic              beat_last, win_last;
    logic [BEAT_W-1:0] beat_lim;
    logic              beat_clr, beat_inc, win_clr, win_inc;

    // One beat counter serves both load phases; its limit follows the phase.
    assign beat_lim = (state_q == LD_INPUT) ? IN_LAST : FILT_LAST;
    assign beat_clr = (state_d != state_q);
    assign beat_inc = (state_q == LD_FILT) || (state_q == LD_INPUT);
    assign win_clr  = (state_q == LD_INPUT);
    assign win_inc  = (state_q == WRITE) && (state_d == LD_TABLE);

    conv_shadow_counter #(.W(BEAT_W)) u_beat_cnt (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (beat_clr),
        .inc_i    (beat_inc),
        .last_i   (beat_lim),
        .last_c_o (beat_last)
    );

    conv_shadow_counter #(.W(WIN_W)) u_win_cnt (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (win_clr),
        .inc_i    (win_inc),
        .last_i   (WIN_LAST),
        .last_c_o (win_last)
    );

    // Next state and sticky error; any carry-out disagreeing with the shadow count aborts to DONE.
    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        mismatch = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = INIT;
                    err_d   = 1'b0;
                end
            end
            INIT:     state_d = LD_FILT;
            LD_FILT: begin
                if (filt_cout_i != beat_last) begin
                    mismatch = 1'b1;
                end else if (beat_last) begin
                    state_d = LD_INPUT;
                end
            end
            LD_INPUT: begin
                if (input_i_cout_i != beat_last) begin
                    mismatch = 1'b1;
                end else if (beat_last) begin
                    state_d = LD_TABLE;
                end
            end
            LD_TABLE: state_d = WRITE;
            WRITE: begin
                if (table_cout_i != win_last) begin
                    mismatch = 1'b1;
                end else if (win_last) begin
                    state_d = DONE;
                end else begin
                    state_d = LD_TABLE;
                end
            end
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        if (mismatch) begin
            state_d = DONE;
            err_d   = 1'b1;
        end
    end

    // Strobes are registered from the next state so they line up with state_q.
    assign ctrl_d = decode(state_d, win_last);

    // State, strobe and error registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ctrl_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            err_q   <= err_d;
        end
    end

    assign x_sel_o          = ctrl_q.x_sel;
    assign y_sel_o          = ctrl_q.y_sel;
    assign z_sel_o          = ctrl_q.z_sel;
    assign x_en_o           = ctrl_q.x_en;
    assign y_en_o           = ctrl_q.y_en;
    assign z_en_o           = ctrl_q.z_en;
    assign mem_in_sel_o     = ctrl_q.mem_in_sel;
    assign mem_rd_o         = ctrl_q.mem_rd;
    assign mem_wr_o         = ctrl_q.mem_wr;
    assign filt_ld_o        = ctrl_q.filt_ld;
    assign filt_count_en_o  = ctrl_q.filt_count_en;
    assign input_en_o       = ctrl_q.input_en;
    assign input_count_en_o = ctrl_q.input_count_en;
    assign tab_count_ld_o   = ctrl_q.tab_count_ld;
    assign table_count_en_o = ctrl_q.table_count_en;
    assign table_ld_o       = ctrl_q.table_ld;
    assign busy_o           = ctrl_q.busy;
    assign done_o           = ctrl_q.done;
    assign err_o            = err_q;

endmodule

// File: tb/tb_conv_controller.sv
// Self-checking bench for conv_controller: default and reduced-size instances.
`timescale 1ns/1ps
module tb_conv_controller;

    typedef struct packed {
        logic       x_sel, y_sel, z_sel, x_en, y_en, z_en;
        logic [1:0] msel;
        logic       rd, wr, filt_ld, filt_cnt, in_en, in_cnt;
        logic       tab_ld_cnt, tab_cnt_en, table_ld, busy, done, err;
    } ov_t;

    typedef struct {
        int fp;   // fault phase: 0 none, 1 filter, 2 input, 3 table
        int fk;   // beat/window at which the carry-out is inverted
        int dc;   // expected done cycle
        int rx;
        int ry;
        int wr;
        bit er;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  start_v, fc_v, ic_v, tc_v;
    wire  [19:0] ob1, ob2;

    int checks;
    int errors;

    ov_t        exq[$];
    logic [2:0] cvq[$];
    bit         tr_err;
    vec_t       vt[8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    conv_controller u_dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_v[0]),
        .filt_cout_i(fc_v[0]), .input_i_cout_i(ic_v[0]), .table_cout_i(tc_v[0]),
        .x_sel_o(ob1[19]), .y_sel_o(ob1[18]), .z_sel_o(ob1[17]),
        .x_en_o(ob1[16]), .y_en_o(ob1[15]), .z_en_o(ob1[14]),
        .mem_in_sel_o(ob1[13:12]), .mem_rd_o(ob1[11]), .mem_wr_o(ob1[10]),
        .filt_ld_o(ob1[9]), .filt_count_en_o(ob1[8]),
        .input_en_o(ob1[7]), .input_count_en_o(ob1[6]),
        .tab_count_ld_o(ob1[5]), .table_count_en_o(ob1[4]), .table_ld_o(ob1[3]),
        .busy_o(ob1[2]), .done_o(ob1[1]), .err_o(ob1[0])
    );

    conv_controller #(.FILT_BEATS(2), .IN_BEATS(8), .WINDOWS(3)) u_dut_small (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_v[1]),
        .filt_cout_i(fc_v[1]), .input_i_cout_i(ic_v[1]), .table_cout_i(tc_v[1]),
        .x_sel_o(ob2[19]), .y_sel_o(ob2[18]), .z_sel_o(ob2[17]),
        .x_en_o(ob2[16]), .y_en_o(ob2[15]), .z_en_o(ob2[14]),
        .mem_in_sel_o(ob2[13:12]), .mem_rd_o(ob2[11]), .mem_wr_o(ob2[10]),
        .filt_ld_o(ob2[9]), .filt_count_en_o(ob2[8]),
        .input_en_o(ob2[7]), .input_count_en_o(ob2[6]),
        .tab_count_ld_o(ob2[5]), .table_count_en_o(ob2[4]), .table_ld_o(ob2[3]),
        .busy_o(ob2[2]), .done_o(ob2[1]), .err_o(ob2[0])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Expected strobes for one phase of a run (p: 1 init, 2 filter, 3 input, 4 table, 5 write, 6 done).
    function automatic ov_t ph(int p, bit tce);
        ov_t v;
        v = '0;
        case (p)
            1: begin v.x_en = 1; v.y_en = 1; v.z_en = 1; v.tab_ld_cnt = 1; v.busy = 1; end
            2: begin v.x_sel = 1; v.x_en = 1; v.msel = 2'b00; v.rd = 1;
                     v.filt_ld = 1; v.filt_cnt = 1; v.busy = 1; end
            3: begin v.y_sel = 1; v.y_en = 1; v.msel = 2'b01; v.rd = 1;
                     v.in_en = 1; v.in_cnt = 1; v.busy = 1; end
            4: begin v.table_ld = 1; v.busy = 1; end
            5: begin v.z_sel = 1; v.z_en = 1; v.msel = 2'b10; v.wr = 1;
                     v.tab_cnt_en = tce; v.busy = 1; end
            6: begin v.done = 1; v.busy = 1; end
            default: ;
        endcase
        return v;
    endfunction

    // Reference trace of one run: the cycle list and the carry-outs a correct datapath would give.
    function automatic void build(int fb, int ib, int w, int fp, int fk);
        bit  ab;
        bit  hit;
        ov_t v;
        ab = 0;
        exq.delete();
        cvq.delete();
        exq.push_back(ph(1, 0)); cvq.push_back(3'b000);
        for (int b = 0; b < fb && !ab; b++) begin
            hit = (fp == 1) && (fk == b);
            exq.push_back(ph(2, 0)); cvq.push_back({(b == fb - 1) ^ hit, 2'b00});
            ab = hit;
        end
        for (int b = 0; b < ib && !ab; b++) begin
            hit = (fp == 2) && (fk == b);
            exq.push_back(ph(3, 0)); cvq.push_back({1'b0, (b == ib - 1) ^ hit, 1'b0});
            ab = hit;
        end
        for (int wi = 0; wi < w && !ab; wi++) begin
            hit = (fp == 3) && (fk == wi);
            exq.push_back(ph(4, 0)); cvq.push_back({2'b00, wi == w - 1});
            exq.push_back(ph(5, wi != w - 1)); cvq.push_back({2'b00, (wi == w - 1) ^ hit});
            ab = hit;
        end
        v = ph(6, 0);
        v.err = ab;
        exq.push_back(v); cvq.push_back(3'b000);
        tr_err = ab;
    endfunction

    task automatic set_cv(input bit sel, input logic [2:0] cv);
        fc_v[sel] = cv[2];
        ic_v[sel] = cv[1];
        tc_v[sel] = cv[0];
    endtask

    // Pulse start, compare every cycle against the reference trace, tally strobes.
    task automatic run(input bit sel, input int fb, input int ib, input int w,
                       input int fp, input int fk, input string nm,
                       output int done_c, output int rdx, output int rdy,
                       output int wr, output bit er);
        ov_t cur;
        ov_t idl;
        build(fb, ib, w, fp, fk);
        done_c = -1; rdx = 0; rdy = 0; wr = 0; er = 0;
        @(negedge clk);
        start_v[sel] = 1'b1;
        @(posedge clk);
        #1 start_v[sel] = 1'b0;
        for (int i = 0; i < exq.size(); i++) begin
            set_cv(sel, cvq[i]);
            @(negedge clk);
            cur = sel ? ov_t'(ob2) : ov_t'(ob1);
            chk($sformatf("%s trace c%0d", nm, i + 1), 32'(cur), 32'(exq[i]));
            if (cur.done && done_c < 0) begin
                done_c = i + 1;
                er     = cur.err;
            end
            if (cur.rd && cur.msel == 2'b00) rdx++;
            if (cur.rd && cur.msel == 2'b01) rdy++;
            if (cur.wr) wr++;
            @(posedge clk);
            #1;
        end
        set_cv(sel, 3'b000);
        @(negedge clk);
        idl = '0;
        idl.err = tr_err;
        cur = sel ? ov_t'(ob2) : ov_t'(ob1);
        chk($sformatf("%s idle after", nm), 32'(cur), 32'(idl));
    endtask

    initial begin
        int  dc, rx, ry, wr, fp, fk, idx, d1, d2, idle_n;
        bit  er, seen_err;
        ov_t cur;
        string nm;

        checks = 0; errors = 0;
        rst_n = 1'b0; start_v = '0; fc_v = '0; ic_v = '0; tc_v = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset dut", 32'(ob1), 32'd0);
        chk("reset small", 32'(ob2), 32'd0);
        rst_n = 1'b1;

        vt[0] = '{0,  0, 48, 4, 16, 13, 1'b0};
        vt[1] = '{1,  2,  5, 3,  0,  0, 1'b1};
        vt[2] = '{3, 12, 48, 4, 16, 13, 1'b1};
        vt[3] = '{0,  0, 48, 4, 16, 13, 1'b0};
        vt[4] = '{1,  3,  6, 4,  0,  0, 1'b1};
        vt[5] = '{2,  5, 12, 4,  6,  0, 1'b1};
        vt[6] = '{3,  0, 24, 4, 16,  1, 1'b1};
        vt[7] = '{2, 15, 22, 4, 16,  0, 1'b1};

        for (int i = 0; i < 8; i++) begin
            nm = $sformatf("v%0d", i);
            run(1'b0, 4, 16, 13, vt[i].fp, vt[i].fk, nm, dc, rx, ry, wr, er);
            chk({nm, " done"}, dc, vt[i].dc);
            chk({nm, " rd_x"}, rx, vt[i].rx);
            chk({nm, " rd_y"}, ry, vt[i].ry);
            chk({nm, " wr"},   wr, vt[i].wr);
            chk({nm, " err"},  32'(er), 32'(vt[i].er));
        end

        for (int i = 0; i < 12; i++) begin
            fp = int'($urandom_range(0, 3));
            fk = (fp == 1) ? int'($urandom_range(0, 3)) :
                 (fp == 2) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 12));
            nm = $sformatf("rnd%0d", i);
            run(1'b0, 4, 16, 13, fp, fk, nm, dc, rx, ry, wr, er);
            chk({nm, " err"}, 32'(er), 32'(fp != 0));
        end

        run(1'b1, 2, 8, 3, 0, 0, "small", dc, rx, ry, wr, er);
        chk("small done", dc, 18);
        chk("small rd_x", rx, 2);
        chk("small rd_y", ry, 8);
        chk("small wr", wr, 3);
        chk("small err", 32'(er), 32'd0);
        for (int i = 0; i < 4; i++) begin
            fp = int'($urandom_range(1, 3));
            fk = (fp == 1) ? int'($urandom_range(0, 1)) :
                 (fp == 2) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 2));
            run(1'b1, 2, 8, 3, fp, fk, $sformatf("small rnd%0d", i), dc, rx, ry, wr, er);
            chk($sformatf("small rnd%0d err", i), 32'(er), 32'd1);
        end

        // Reset in the middle of the input load aborts with every output low.
        build(4, 16, 13, 0, 0);
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        for (int i = 0; i < 9; i++) begin
            set_cv(1'b0, cvq[i]);
            @(posedge clk);
            #1;
        end
        set_cv(1'b0, cvq[9]);
        chk("pre-reset busy", 32'(ob1[2]), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("async reset", 32'(ob1), 32'd0);
        set_cv(1'b0, 3'b000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset held", 32'(ob1), 32'd0);
        rst_n = 1'b1;
        run(1'b0, 4, 16, 13, 0, 0, "post-reset", dc, rx, ry, wr, er);
        chk("post-reset done", dc, 48);
        chk("post-reset err", 32'(er), 32'd0);

        // Start held high across two back-to-back runs.
        build(4, 16, 13, 0, 0);
        d1 = -1; d2 = -1; idle_n = 0; seen_err = 0;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 1; c <= 97; c++) begin
            idx = (c <= 48) ? c - 1 : c - 50;
            set_cv(1'b0, (idx >= 0 && idx < exq.size()) ? cvq[idx] : 3'b000);
            @(negedge clk);
            cur = ov_t'(ob1);
            if (cur.done) begin
                if (d1 < 0) d1 = c;
                else if (d2 < 0) d2 = c;
            end
            if (d1 > 0 && d2 < 0 && !cur.busy) idle_n++;
            if (cur.err) seen_err = 1;
            @(posedge clk);
            #1;
        end
        start_v[0] = 1'b0;
        set_cv(1'b0, 3'b000);
        chk("held first done", d1, 48);
        chk("held run gap", (d2 < 0) ? -1 : d2 - d1, 49);
        chk("held idle cycles", idle_n, 1);
        chk("held err", 32'(seen_err), 32'd0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("final idle", 32'(ob1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
